// File: rtl/game_step_ctrl.sv
// +----------------------------------------------------------------------------+
// | game_step_ctrl : live Sokoban state, paced walk toward a clicked cell,     |
// |                  level load, step counter, circular undo, win detection.   |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module game_step_ctrl #(
  parameter int STEP_CYCLES = 2500000,
  parameter int CNT_W       = 22,
  parameter int UNDO_DEPTH  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [133:0] level_state,
  input  logic [63:0]  level_target,
  input  logic         click,
  input  logic [5:0]   cursor,
  input  logic         undo,
  input  logic [133:0] mv_state_next,
  input  logic         mv_result,
  input  logic [1:0]   mv_direction,
  output logic [133:0] game_state,
  output logic [5:0]   goal,
  output logic         busy,
  output logic         win,
  output logic [15:0]  step_count,
  output logic [1:0]   direction,
  output logic         step_pulse
);

  localparam int PTR_W  = (UNDO_DEPTH > 1) ? $clog2(UNDO_DEPTH) : 1;
  localparam int HCNT_W = $clog2(UNDO_DEPTH + 1);
  localparam logic [CNT_W-1:0]  PACE_RELOAD = CNT_W'(STEP_CYCLES - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST    = PTR_W'(UNDO_DEPTH - 1);
  localparam logic [HCNT_W-1:0] HIST_FULL   = HCNT_W'(UNDO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WALK = 2'd1,
    S_WAIT = 2'd2,
    S_WON  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [133:0]        game_state_q, game_state_d;
  logic [63:0]         targets_q, targets_d;
  logic [5:0]          goal_q, goal_d;
  logic [15:0]         step_count_q, step_count_d;
  logic [1:0]          direction_q, direction_d;
  logic                step_pulse_q, step_pulse_d;
  logic                busy_q, busy_d;
  logic                win_q, win_d;
  logic [CNT_W-1:0]    pace_q, pace_d;
  logic [133:0]        hist_q [UNDO_DEPTH];
  logic [133:0]        hist_d [UNDO_DEPTH];
  logic [PTR_W-1:0]    hist_ptr_q, hist_ptr_d;
  logic [HCNT_W-1:0]   hist_cnt_q, hist_cnt_d;

  logic                win_cond;
  logic                hist_empty;
  logic [PTR_W-1:0]    ptr_next;
  logic [PTR_W-1:0]    ptr_prev;

  assign win_cond   = (game_state_q[69:6] == targets_q) && (targets_q != 64'd0);
  assign hist_empty = (hist_cnt_q == '0);
  // hist_ptr points at the next free slot; the newest entry sits just behind it
  assign ptr_next   = (hist_ptr_q == PTR_LAST) ? '0 : hist_ptr_q + PTR_W'(1);
  assign ptr_prev   = (hist_ptr_q == '0) ? PTR_LAST : hist_ptr_q - PTR_W'(1);

  always_comb begin
    state_d      = state_q;
    game_state_d = game_state_q;
    targets_d    = targets_q;
    goal_d       = goal_q;
    step_count_d = step_count_q;
    direction_d  = direction_q;
    step_pulse_d = 1'b0;
    pace_d       = pace_q;
    hist_d       = hist_q;
    hist_ptr_d   = hist_ptr_q;
    hist_cnt_d   = hist_cnt_q;

    if (load) begin
      game_state_d = level_state;
      targets_d    = level_target;
      step_count_d = 16'd0;
      hist_ptr_d   = '0;
      hist_cnt_d   = '0;
      pace_d       = '0;
      state_d      = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_WON: begin
          if (undo) begin
            if (!hist_empty) begin
              game_state_d = hist_q[ptr_prev];
              hist_ptr_d   = ptr_prev;
              hist_cnt_d   = hist_cnt_q - HCNT_W'(1);
              step_count_d = (step_count_q == 16'd0) ? 16'd0 : step_count_q - 16'd1;
              state_d      = S_IDLE;
            end
          end else if (click && (state_q == S_IDLE) && (cursor != game_state_q[5:0])) begin
            goal_d  = cursor;
            state_d = S_WALK;
          end
        end
        S_WALK: begin
          if (mv_result) begin
            game_state_d         = mv_state_next;
            hist_d[hist_ptr_q]   = game_state_q;
            hist_ptr_d           = ptr_next;
            hist_cnt_d           = (hist_cnt_q == HIST_FULL) ? hist_cnt_q : hist_cnt_q + HCNT_W'(1);
            step_count_d         = (step_count_q == 16'hFFFF) ? step_count_q : step_count_q + 16'd1;
            direction_d          = mv_direction;
            step_pulse_d         = 1'b1;
            pace_d               = PACE_RELOAD;
            state_d              = S_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WAIT: begin
          if (pace_q != '0) begin
            pace_d = pace_q - CNT_W'(1);
          end else if (win_cond) begin
            state_d = S_WON;
          end else if (game_state_q[5:0] == goal_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WALK;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_WALK) || (state_d == S_WAIT);
    win_d  = (state_d == S_WON);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      game_state_q <= '0;
      targets_q    <= '0;
      goal_q       <= '0;
      step_count_q <= '0;
      direction_q  <= '0;
      step_pulse_q <= 1'b0;
      busy_q       <= 1'b0;
      win_q        <= 1'b0;
      pace_q       <= '0;
      hist_ptr_q   <= '0;
      hist_cnt_q   <= '0;
      for (int i = 0; i < UNDO_DEPTH; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      game_state_q <= game_state_d;
      targets_q    <= targets_d;
      goal_q       <= goal_d;
      step_count_q <= step_count_d;
      direction_q  <= direction_d;
      step_pulse_q <= step_pulse_d;
      busy_q       <= busy_d;
      win_q        <= win_d;
      pace_q       <= pace_d;
      hist_ptr_q   <= hist_ptr_d;
      hist_cnt_q   <= hist_cnt_d;
      for (int i = 0; i < UNDO_DEPTH; i++) begin
        hist_q[i] <= hist_d[i];
      end
    end
  end

  assign game_state = game_state_q;
  assign goal       = goal_q;
  assign busy       = busy_q;
  assign win        = win_q;
  assign step_count = step_count_q;
  assign direction  = direction_q;
  assign step_pulse = step_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_game_step_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_game_step_ctrl : directed and random stimulus against a game-level model |
// | Revision          : 1.0                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_game_step_ctrl;

  localparam int STEP = 4;

  typedef logic [133:0] st_t;
  typedef struct packed {
    logic [1:0] dir;
    logic       ok;
    st_t        ns;
  } mv_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load = 1'b0;
  logic         click = 1'b0;
  logic         undo = 1'b0;
  logic [133:0] level_state = '0;
  logic [63:0]  level_target = '0;
  logic [5:0]   cursor = '0;
  logic [133:0] mv_state_next;
  logic         mv_result;
  logic [1:0]   mv_direction;
  logic [133:0] game_state;
  logic [5:0]   goal;
  logic         busy, win, step_pulse;
  logic [15:0]  step_count;
  logic [1:0]   direction;

  int errors = 0;
  int checks = 0;

  // game-level model state
  st_t        m_gs;
  logic [63:0] m_tg;
  int         m_cnt;
  st_t        m_hist[$];
  bit         m_won;
  logic [1:0] m_dir;

  int         pt[$];
  bit         bq[64];

  game_step_ctrl #(.STEP_CYCLES(STEP), .CNT_W(4), .UNDO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .level_state(level_state),
    .level_target(level_target), .click(click), .cursor(cursor), .undo(undo),
    .mv_state_next(mv_state_next), .mv_result(mv_result), .mv_direction(mv_direction),
    .game_state(game_state), .goal(goal), .busy(busy), .win(win),
    .step_count(step_count), .direction(direction), .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  // One Sokoban step toward cur: horizontal first, then vertical; pushes a single box.
  function automatic mv_t man_step(st_t s, logic [5:0] cur);
    mv_t r;
    logic [63:0] way, box;
    int y, x, cy, cx, dy, dx, n1, n2, y2, x2;
    way = s[133:70]; box = s[69:6];
    y = int'(s[5:3]); x = int'(s[2:0]); cy = int'(cur[5:3]); cx = int'(cur[2:0]);
    r.ns = s; r.ok = 1'b0; r.dir = 2'd0; dy = 0; dx = 0;
    if (cx > x)      begin r.dir = 2'd3; dx = 1;  end
    else if (cx < x) begin r.dir = 2'd2; dx = -1; end
    else if (cy > y) begin r.dir = 2'd1; dy = 1;  end
    else if (cy < y) begin r.dir = 2'd0; dy = -1; end
    else return r;
    n1 = (y + dy) * 8 + x + dx;
    y2 = y + 2 * dy; x2 = x + 2 * dx;
    if (!way[n1]) return r;
    if (box[n1]) begin
      if (y2 < 0 || y2 > 7 || x2 < 0 || x2 > 7) return r;
      n2 = y2 * 8 + x2;
      if (!way[n2] || box[n2]) return r;
      box[n1] = 1'b0; box[n2] = 1'b1;
    end
    r.ok = 1'b1;
    r.ns = {way, box, 3'(y + dy), 3'(x + dx)};
    return r;
  endfunction

  mv_t env;
  always_comb env = man_step(game_state, goal);
  assign mv_state_next = env.ns;
  assign mv_result     = env.ok;
  assign mv_direction  = env.dir;

  function automatic bit is_win(st_t s, logic [63:0] t);
    return (s[69:6] == t) && (t != 64'd0);
  endfunction

  function automatic st_t rand_level();
    logic [63:0] w, b;
    logic [5:0] m;
    w = {$urandom, $urandom} | {$urandom, $urandom};
    b = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom} & w;
    m = 6'($urandom_range(0, 63));
    w[m] = 1'b1; b[m] = 1'b0;
    return {w, b, m};
  endfunction

  task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic m_reset();
    m_gs = '0; m_tg = '0; m_cnt = 0; m_hist.delete(); m_won = 1'b0; m_dir = 2'd0;
  endtask

  task automatic m_load(input st_t s, input logic [63:0] t);
    m_gs = s; m_tg = t; m_cnt = 0; m_hist.delete(); m_won = 1'b0;
  endtask

  task automatic m_click(input logic [5:0] cur, output int steps);
    mv_t r;
    steps = 0;
    if (m_won || cur == m_gs[5:0]) return;
    for (int i = 0; i < 64; i++) begin
      r = man_step(m_gs, cur);
      if (!r.ok) break;
      m_hist.push_back(m_gs);
      if (m_hist.size() > 4) void'(m_hist.pop_front());
      m_gs = r.ns; m_dir = r.dir;
      if (m_cnt < 65535) m_cnt++;
      steps++;
      if (is_win(m_gs, m_tg)) begin m_won = 1'b1; break; end
      if (m_gs[5:0] == cur) break;
    end
  endtask

  task automatic m_undo();
    if (m_hist.size() > 0) begin
      m_gs = m_hist.pop_back();
      if (m_cnt > 0) m_cnt--;
      m_won = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".gs"}, game_state, m_gs);
    chk({tag, ".cnt"}, step_count, 134'(m_cnt));
    chk({tag, ".win"}, win, m_won);
    chk({tag, ".dir"}, direction, m_dir);
    chk({tag, ".busy"}, busy, 1'b0);
  endtask

  task automatic dut_load(input st_t s, input logic [63:0] t);
    level_state = s; level_target = t; load = 1'b1;
    tick();
    load = 1'b0;
    m_load(s, t);
  endtask

  task automatic dut_undo();
    undo = 1'b1;
    tick();
    undo = 1'b0;
    m_undo();
  endtask

  task automatic dut_click(input logic [5:0] cur, output int pulses);
    pulses = 0;
    cursor = cur; click = 1'b1;
    tick();
    click = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!busy) break;
      tick();
      if (step_pulse) pulses++;
    end
  endtask

  task automatic click_and_check(input string tag, input logic [5:0] cur);
    int p, s;
    dut_click(cur, p);
    m_click(cur, s);
    chk({tag, ".pulses"}, 134'(p), 134'(s));
    check_all(tag);
  endtask

  task automatic wait_pulse(input string tag);
    for (int i = 0; i < 50; i++) begin
      if (step_pulse) break;
      tick();
    end
    chk(tag, step_pulse, 1'b1);
  endtask

  localparam logic [63:0] ROW1 = 64'h0000_0000_0000_FF00;

  initial begin
    st_t lv;
    int lp;
    m_reset();

    // reset state
    tick(); tick();
    check_all("reset");
    chk("reset.goal", goal, 6'd0);
    chk("reset.pulse", step_pulse, 1'b0);
    rst_n = 1'b1;
    tick();

    // asynchronous reset in the middle of a paced walk
    dut_load({ROW1, 64'd0, 6'o11}, 64'd0);
    cursor = 6'o16; click = 1'b1;
    tick();
    click = 1'b0;
    wait_pulse("t1.pulse");
    tick();
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("t1.gs", game_state, 134'd0);
    chk("t1.busy", busy, 1'b0);
    chk("t1.cnt", step_count, 16'd0);
    chk("t1.goal", goal, 6'd0);
    tick();
    rst_n = 1'b1;
    tick();
    dut_load({ROW1, 64'd0, 6'o11}, 64'd0);
    click_and_check("t1.after", 6'o16);

    // three paced steps to the right
    dut_load({ROW1, 64'd0, 6'o11}, 64'd0);
    pt.delete();
    cursor = 6'o14; click = 1'b1;
    tick();
    click = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      bq[i] = busy;
      if (step_pulse) pt.push_back(i);
    end
    chk("t2.npulse", 134'(pt.size()), 134'd3);
    chk("t2.first", 134'((pt.size() > 0 && pt[0] <= 1) ? 1 : 0), 134'd1);
    chk("t2.gap1", 134'((pt.size() > 1) ? pt[1] - pt[0] : -1), 134'(STEP + 1));
    chk("t2.gap2", 134'((pt.size() > 2) ? pt[2] - pt[1] : -1), 134'(STEP + 1));
    lp = (pt.size() > 0) ? pt[pt.size() - 1] : 0;
    chk("t2.busy_hold", bq[lp + 3], 1'b1);
    chk("t2.busy_fall", bq[lp + 5], 1'b0);
    chk("t2.man", game_state[5:0], 6'o14);
    chk("t2.cnt", step_count, 16'd3);
    chk("t2.dir", direction, 2'd3);

    // push the only box onto the only target
    dut_load({ROW1, 64'h400, 6'o11}, 64'h800);
    click_and_check("t3.push", 6'o14);
    chk("t3.win", win, 1'b1);
    click_and_check("t3.ignored", 6'o10);
    dut_undo();
    check_all("t3.undo");
    chk("t3.boxback", game_state[6 + 10], 1'b1);

    // wall in the way on the first step
    dut_load({64'h1200, 64'd0, 6'o11}, 64'd0);
    cursor = 6'o14; click = 1'b1;
    tick();
    click = 1'b0;
    chk("t4.walk", busy, 1'b1);
    tick();
    chk("t4.idle", busy, 1'b0);
    chk("t4.pulse", step_pulse, 1'b0);
    chk("t4.cnt", step_count, 16'd0);

    // five steps then five undos through a 4-deep history
    dut_load({ROW1, 64'd0, 6'o10}, 64'd0);
    click_and_check("t5.walk", 6'o15);
    for (int i = 0; i < 5; i++) begin
      dut_undo();
      check_all($sformatf("t5.undo%0d", i));
    end
    chk("t5.state1", game_state, {ROW1, 64'd0, 6'o11});
    chk("t5.cnt1", step_count, 16'd1);

    // load wins over click and undo while walking
    dut_load({ROW1, 64'd0, 6'o11}, 64'd0);
    cursor = 6'o16; click = 1'b1;
    tick();
    click = 1'b0;
    wait_pulse("t6.pulse");
    tick();
    lv = rand_level();
    level_state = lv; level_target = 64'd0;
    load = 1'b1; click = 1'b1; undo = 1'b1; cursor = 6'o77;
    tick();
    load = 1'b0; click = 1'b0; undo = 1'b0;
    m_load(lv, 64'd0);
    check_all("t6.load");
    dut_undo();
    check_all("t6.undo_empty");

    // random levels, clicks and undos
    dut_load(rand_level(), {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
    for (int i = 0; i < 80; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op == 0)
        dut_load(rand_level(), {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
      else if (op < 7)
        click_and_check($sformatf("rnd%0d.click", i), 6'($urandom_range(0, 63)));
      else begin
        dut_undo();
        check_all($sformatf("rnd%0d.undo", i));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
